// File: rtl/c_fetch_pkg.sv
// c_fetch_pkg: shared state type, NOP constant and RVC predicate for the fetch realigner
package c_fetch_pkg;
  typedef enum logic {S_RUN, S_SKIP_LO} state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/c_fetch_realigner_fifo.sv
// c_hw_fifo: halfword circular buffer with 2-wide write, 2-wide peek and 0/1/2 pop
module c_hw_fifo #(
  parameter int DEPTH_HW = 6,
  parameter int CW = $clog2(DEPTH_HW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          push_en_i,
  input  logic          push_two_i,
  input  logic [15:0]   push_lo_i,
  input  logic [15:0]   push_hi_i,
  input  logic [1:0]    pop_cnt_i,
  output logic [15:0]   h0_o,
  output logic [15:0]   h1_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH_HW);
  localparam logic [PW+1:0] DEPTH_S = (PW+2)'(DEPTH_HW);
  logic [15:0] mem_q [DEPTH_HW];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wr1, rd1;
  logic [CW-1:0] count_q, count_d;
  // pointers wrap modulo DEPTH_HW, which need not be a power of two
  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW+1:0] s;
    s = {2'b00, p} + {{PW{1'b0}}, k};
    s = s >= DEPTH_S ? s - DEPTH_S : s;
    return s[PW-1:0];
  endfunction
  always_comb begin
    wr1 = adv(wr_q, 2'd1);
    rd1 = adv(rd_q, 2'd1);
    wr_d = clear_i ? '0 : push_en_i ? adv(wr_q, push_two_i ? 2'd2 : 2'd1) : wr_q;
    rd_d = clear_i ? '0 : adv(rd_q, pop_cnt_i);
    count_d = clear_i ? '0 : count_q + (push_en_i ? (push_two_i ? CW'(2) : CW'(1)) : CW'(0)) - CW'(pop_cnt_i);
  end
  always_ff @(posedge clk) begin
    if (push_en_i && !clear_i) begin
      mem_q[wr_q] <= push_lo_i;
      if (push_two_i) mem_q[wr1] <= push_hi_i;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  end
  assign h0_o = mem_q[rd_q];
  assign h1_o = mem_q[rd1];
  assign count_o = count_q;
endmodule

// File: rtl/c_fetch_realigner.sv
// c_fetch_realigner: turns aligned fetch words into one 16/32-bit instruction per cycle with its PC
module c_fetch_realigner
  import c_fetch_pkg::*;
#(
  parameter int          DEPTH_HW = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_word_i,
  output logic        fetch_ready_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_compressed_o,
  output logic        straddle_o
);
  localparam int CW = $clog2(DEPTH_HW + 1);
  state_e state_q;
  logic [31:0] pc_q;
  logic [CW-1:0] count;
  logic [15:0] h0, h1;
  logic rvc, skip, push, pop;
  logic [1:0] pop_cnt;
  always_comb begin
    rvc = is_rvc(h0);
    skip = state_q == S_SKIP_LO;
    fetch_ready_o = count <= CW'(DEPTH_HW - 2);
    push = fetch_valid_i && fetch_ready_o && !flush_i;
    inst_valid_o = !flush_i && (count > CW'(1) || (count == CW'(1) && rvc));
    pop = inst_valid_o && inst_ready_i;
    pop_cnt = pop ? (rvc ? 2'd1 : 2'd2) : 2'd0;
    inst_compressed_o = inst_valid_o && rvc;
    inst_o = !inst_valid_o ? NOP_INST : rvc ? {16'h0, h0} : {h1, h0};
    straddle_o = !flush_i && count == CW'(1) && !rvc;
    inst_pc_o = pc_q;
  end
  c_hw_fifo #(.DEPTH_HW(DEPTH_HW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (flush_i),
    .push_en_i  (push),
    .push_two_i (!skip),
    .push_lo_i  (skip ? fetch_word_i[31:16] : fetch_word_i[15:0]),
    .push_hi_i  (fetch_word_i[31:16]),
    .pop_cnt_i  (pop_cnt),
    .h0_o       (h0),
    .h1_o       (h1),
    .count_o    (count)
  );
  // a redirect to an odd halfword drops the low half of the first word fetched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q <= RESET_PC;
    end else if (flush_i) begin
      state_q <= flush_pc_i[1] ? S_SKIP_LO : S_RUN;
      pc_q <= {flush_pc_i[31:1], 1'b0};
    end else begin
      if (push) state_q <= S_RUN;
      pc_q <= pc_q + {29'd0, pop_cnt, 1'b0};
    end
  end
endmodule

// File: tb/tb_c_fetch_realigner.sv
// tb_c_fetch_realigner: scoreboard bench for the fetch realigner
module tb_c_fetch_realigner;
  import c_fetch_pkg::*;
  logic clk = 0, reset = 0, flush_i = 0, fetch_valid_i = 0, inst_ready_i = 0;
  logic [31:0] flush_pc_i = 0, fetch_word_i = 0;
  logic fetch_ready_o, inst_valid_o, inst_compressed_o, straddle_o;
  logic [31:0] inst_o, inst_pc_o;
  typedef struct packed {logic [31:0] inst; logic [31:0] pc; logic c;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [31:0] w5 [4] = '{32'h0010_0113, 32'h0020_0193, 32'h0030_0213, 32'h0040_0293};

  c_fetch_realigner dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_word_i(fetch_word_i), .fetch_ready_o(fetch_ready_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_compressed_o(inst_compressed_o), .straddle_o(straddle_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && inst_valid_o && inst_ready_i) begin
      if (sb.size() == 0) chk("spurious_inst", inst_o, NOP);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_inst", inst_o, e.inst);
        chk("sb_pc", inst_pc_o, e.pc);
        chk("sb_rvc", {31'd0, inst_compressed_o}, {31'd0, e.c});
      end
    end
  end

  task automatic push_w(input logic [31:0] w);
    fetch_valid_i = 1;
    fetch_word_i = w;
    @(posedge clk); #1;
    fetch_valid_i = 0;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    flush_i = 1;
    flush_pc_i = pc;
    @(posedge clk); #1;
    flush_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int idx;
    logic r, fv;
    #1 reset = 1;
    @(negedge clk);
    chk("rst_valid", {31'd0, inst_valid_o}, 0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_rvc", {31'd0, inst_compressed_o}, 0);
    chk("rst_straddle", {31'd0, straddle_o}, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", {31'd0, fetch_ready_o}, 1);
    // 1: single 32-bit instruction, one cycle latency
    @(posedge clk); #1;
    inst_ready_i = 1;
    sb.push_back('{32'h0010_0093, 32'h0, 1'b0});
    push_w(32'h0010_0093);
    @(negedge clk);
    chk("lat_valid", {31'd0, inst_valid_o}, 1);
    idle(1);
    // 2: two compressed instructions in one word
    flush_to(0);
    sb.push_back('{32'h0000_4501, 32'h0, 1'b1});
    sb.push_back('{32'h0000_4505, 32'h2, 1'b1});
    push_w(32'h4505_4501);
    idle(3);
    // 3: 32-bit instruction straddling two words
    flush_to(0);
    sb.push_back('{32'h0000_4501, 32'h0, 1'b1});
    sb.push_back('{32'h0010_0093, 32'h2, 1'b0});
    sb.push_back('{32'h0000_4505, 32'h6, 1'b1});
    push_w(32'h0093_4501);
    idle(1);
    @(negedge clk);
    chk("strad_flag", {31'd0, straddle_o}, 1);
    chk("strad_nop", inst_o, NOP);
    chk("strad_valid", {31'd0, inst_valid_o}, 0);
    idle(1);
    @(negedge clk);
    chk("strad_flag2", {31'd0, straddle_o}, 1);
    @(posedge clk); #1;
    push_w(32'h4505_0010);
    idle(3);
    // 4: redirect to an odd halfword
    flush_to(32'h0000_0102);
    @(negedge clk);
    chk("skip_idle", {31'd0, inst_valid_o}, 0);
    @(posedge clk); #1;
    sb.push_back('{32'h0000_4509, 32'h102, 1'b1});
    push_w(32'h4509_FFFF);
    idle(2);
    // 5: fill to full with decode stalled, then drain
    flush_to(0);
    inst_ready_i = 0;
    fetch_valid_i = 1;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) fetch_word_i = w5[idx];
      if (c == 6) inst_ready_i = 1;
      @(negedge clk);
      if (c >= 3 && c <= 6) chk("full_ready", {31'd0, fetch_ready_o}, 0);
      if (c == 3) chk("full_words", idx, 3);
      if (c == 7) chk("ready_rise", {31'd0, fetch_ready_o}, 1);
      r = fetch_ready_o;
      fv = fetch_valid_i;
      @(posedge clk); #1;
      if (r && fv) begin
        sb.push_back('{w5[idx], 32'(idx * 4), 1'b0});
        idx++;
        if (idx == 4) fetch_valid_i = 0;
      end
    end
    chk("drain_words", idx, 4);
    // 6: flush wins over push and pop, then async reset mid-straddle
    flush_to(0);
    inst_ready_i = 0;
    push_w(32'h0010_0093);
    flush_i = 1;
    flush_pc_i = 32'h40;
    fetch_valid_i = 1;
    fetch_word_i = 32'h0020_0113;
    inst_ready_i = 1;
    @(negedge clk);
    chk("flush_valid", {31'd0, inst_valid_o}, 0);
    @(posedge clk); #1;
    flush_i = 0;
    fetch_valid_i = 0;
    @(negedge clk);
    chk("flush_drop", {31'd0, inst_valid_o}, 0);
    chk("flush_pc", inst_pc_o, 32'h40);
    @(posedge clk); #1;
    sb.push_back('{32'h0000_4501, 32'h40, 1'b1});
    push_w(32'h0093_4501);
    idle(1);
    @(negedge clk);
    chk("rs_straddle", {31'd0, straddle_o}, 1);
    #2 reset = 1;
    #1;
    chk("ar_valid", {31'd0, inst_valid_o}, 0);
    chk("ar_inst", inst_o, NOP);
    chk("ar_straddle", {31'd0, straddle_o}, 0);
    chk("ar_pc", inst_pc_o, 0);
    chk("ar_rvc", {31'd0, inst_compressed_o}, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, inst_valid_o}, 0);
    @(posedge clk); #1;
    sb.push_back('{32'h0010_0093, 32'h0, 1'b0});
    push_w(32'h0010_0093);
    idle(2);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
